// File: rtl/seven_seg_scan_driver.sv
// Multiplexed common-anode 7-segment scan driver with per-digit
// blanking, blinking, leading-zero blanking and per-frame snapshots.
module seven_seg_scan_driver #(
    parameter int NUM_DIGITS       = 4,
    parameter int PRESCALE         = 50000,
    parameter int BLINK_DIV        = 64,
    parameter bit ANODE_ACTIVE_LOW = 1'b1
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic                    Enable,
    input  logic [4*NUM_DIGITS-1:0] Digits,
    input  logic [NUM_DIGITS-1:0]   BlankMask,
    input  logic [NUM_DIGITS-1:0]   BlinkMask,
    input  logic                    LeadZeroBlank,
    output logic [7:0]              Cathodes,
    output logic [NUM_DIGITS-1:0]   Anodes,
    output logic                    FrameStart
);

    localparam int PW = $clog2(PRESCALE);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
    localparam logic [FW-1:0] FRM_LAST = FW'(BLINK_DIV - 1);
    localparam logic [NUM_DIGITS-1:0] AN_OFF = {NUM_DIGITS{ANODE_ACTIVE_LOW}};

    // Code to active-low {a,b,c,d,e,f,g,dp}; 9..B show F., E., S.
    function automatic logic [7:0] seg_decode(input logic [3:0] c);
        logic [7:0] s;
        case (c)
            4'h0:    s = 8'h03;
            4'h1:    s = 8'h9F;
            4'h2:    s = 8'h25;
            4'h3:    s = 8'h0D;
            4'h4:    s = 8'h99;
            4'h5:    s = 8'h49;
            4'h6:    s = 8'h41;
            4'h7:    s = 8'h1F;
            4'h8:    s = 8'h01;
            4'h9:    s = 8'h70;
            4'hA:    s = 8'h60;
            4'hB:    s = 8'h48;
            default: s = 8'hFF;
        endcase
        return s;
    endfunction

    logic [PW-1:0]           pre_q, pre_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [FW-1:0]           fcnt_q, fcnt_d;
    logic                    phase_q, phase_d;
    logic                    ptick_q, ptick_d;
    logic                    fs_q, fs_d;
    logic [4*NUM_DIGITS-1:0] code_q, code_d;
    logic [NUM_DIGITS-1:0]   blank_q, blank_d;
    logic [NUM_DIGITS-1:0]   blink_q, blink_d;
    logic                    lzb_q, lzb_d;
    logic [7:0]              cath_q, cath_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;

    logic                    tick;
    logic                    lz_run;
    logic [NUM_DIGITS-1:0]   lz_vec;
    logic [3:0]              cur_code;
    logic                    cur_blank;
    logic                    cur_blink;
    logic                    cur_lz;
    logic [NUM_DIGITS-1:0]   an_sel;
    logic [7:0]              glyph;

    assign tick = Enable && (pre_q == PRE_LAST);

    // Glyph and anode pattern of the digit at the current scan index.
    always_comb begin
        lz_run    = 1'b1;
        lz_vec    = '0;
        cur_code  = 4'hF;
        cur_blank = 1'b0;
        cur_blink = 1'b0;
        cur_lz    = 1'b0;
        an_sel    = AN_OFF;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            lz_run    = lz_run && (code_q[4*i +: 4] == 4'h0);
            lz_vec[i] = lz_run;
        end
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                cur_code  = code_q[4*i +: 4];
                cur_blank = blank_q[i];
                cur_blink = blink_q[i];
                cur_lz    = (i != 0) && lz_vec[i];
                an_sel[i] = ~ANODE_ACTIVE_LOW;
            end
        end
        if (cur_blank) begin
            glyph = 8'hFF;
        end else if (phase_q && cur_blink) begin
            glyph = 8'hFF;
        end else if (lzb_q && cur_lz) begin
            glyph = 8'hFF;
        end else begin
            glyph = seg_decode(cur_code);
        end
    end

    // Next-state: prescaler, scan index, snapshot, blink timing, outputs.
    always_comb begin
        pre_d   = pre_q;
        idx_d   = idx_q;
        fcnt_d  = fcnt_q;
        phase_d = phase_q;
        ptick_d = tick;
        fs_d    = 1'b0;
        code_d  = code_q;
        blank_d = blank_q;
        blink_d = blink_q;
        lzb_d   = lzb_q;
        cath_d  = cath_q;
        an_d    = an_q;

        if (Enable) begin
            pre_d = tick ? '0 : pre_q + PW'(1);
        end

        if (tick) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
            an_d  = AN_OFF;
            if (idx_d == '0) begin
                code_d  = Digits;
                blank_d = BlankMask;
                blink_d = BlinkMask;
                lzb_d   = LeadZeroBlank;
                fs_d    = 1'b1;
            end
        end

        if (fs_q) begin
            if (fcnt_q == FRM_LAST) begin
                fcnt_d  = '0;
                phase_d = ~phase_q;
            end else begin
                fcnt_d = fcnt_q + FW'(1);
            end
        end

        if (!Enable) begin
            an_d   = AN_OFF;
            cath_d = 8'hFF;
        end else if (ptick_q) begin
            an_d   = an_sel;
            cath_d = glyph;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            pre_q   <= '0;
            idx_q   <= IDX_LAST;
            fcnt_q  <= '0;
            phase_q <= 1'b0;
            ptick_q <= 1'b0;
            fs_q    <= 1'b0;
            code_q  <= {NUM_DIGITS{4'hF}};
            blank_q <= '0;
            blink_q <= '0;
            lzb_q   <= 1'b0;
            cath_q  <= 8'hFF;
            an_q    <= AN_OFF;
        end else begin
            pre_q   <= pre_d;
            idx_q   <= idx_d;
            fcnt_q  <= fcnt_d;
            phase_q <= phase_d;
            ptick_q <= ptick_d;
            fs_q    <= fs_d;
            code_q  <= code_d;
            blank_q <= blank_d;
            blink_q <= blink_d;
            lzb_q   <= lzb_d;
            cath_q  <= cath_d;
            an_q    <= an_d;
        end
    end

    assign Cathodes   = cath_q;
    assign Anodes     = an_q;
    assign FrameStart = fs_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Bench for seven_seg_scan_driver: expected digit glyphs are queued
// per frame and compared as the scan lights each digit.
module tb_seven_seg_scan_driver;

    localparam int ND = 4;

    typedef struct {
        logic [3:0] an;
        logic [7:0] cat;
    } exp_t;

    localparam logic [7:0] SEG [16] = '{
        8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
        8'h01, 8'h70, 8'h60, 8'h48, 8'hFF, 8'hFF, 8'hFF, 8'hFF
    };

    logic        Clock;
    logic        Reset;
    logic        Enable;
    logic [15:0] Digits;
    logic [3:0]  BlankMask;
    logic [3:0]  BlinkMask;
    logic        LeadZeroBlank;
    logic [7:0]  Cathodes;
    logic [3:0]  Anodes;
    logic        FrameStart;

    int errors = 0;
    int checks = 0;
    exp_t sb[$];

    seven_seg_scan_driver #(
        .NUM_DIGITS(4),
        .PRESCALE(4),
        .BLINK_DIV(2),
        .ANODE_ACTIVE_LOW(1'b1)
    ) dut (
        .Clock(Clock),
        .Reset(Reset),
        .Enable(Enable),
        .Digits(Digits),
        .BlankMask(BlankMask),
        .BlinkMask(BlinkMask),
        .LeadZeroBlank(LeadZeroBlank),
        .Cathodes(Cathodes),
        .Anodes(Anodes),
        .FrameStart(FrameStart)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    // Reference glyph for digit i of a frame snapshot.
    function automatic logic [7:0] model_glyph(input logic [15:0] dg,
                                               input logic [3:0] bl,
                                               input logic [3:0] bk,
                                               input logic lzb,
                                               input logic ph,
                                               input int i);
        logic allz;
        logic [3:0] c;
        allz = 1'b1;
        for (int k = i; k < ND; k++) begin
            c = dg[4*k +: 4];
            if (c != 4'h0) allz = 1'b0;
        end
        c = dg[4*i +: 4];
        if (bl[i]) return 8'hFF;
        if (ph && bk[i]) return 8'hFF;
        if (i > 0 && lzb && allz) return 8'hFF;
        return SEG[c];
    endfunction

    task automatic push_frame(input logic [15:0] dg, input logic [3:0] bl,
                              input logic [3:0] bk, input logic lzb,
                              input logic ph);
        exp_t e;
        for (int i = 0; i < ND; i++) begin
            e.an  = ~(4'b0001 << i);
            e.cat = model_glyph(dg, bl, bk, lzb, ph, i);
            sb.push_back(e);
        end
    endtask

    task automatic wait_fs(input bit skip, output bit ok);
        ok = 1'b0;
        if (skip) @(negedge Clock);
        for (int k = 0; k < 40; k++) begin
            if (FrameStart === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge Clock);
        end
    endtask

    task automatic check_frame(input string name, input bit skip);
        exp_t e;
        bit ok;
        wait_fs(skip, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s frame_start: no pulse within 40 cycles", name);
            repeat (ND) if (sb.size() > 0) void'(sb.pop_front());
            return;
        end
        for (int d = 0; d < ND; d++) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL %s scoreboard empty at digit %0d", name, d);
                return;
            end
            e = sb.pop_front();
            @(negedge Clock);
            checks++;
            if (Anodes !== e.an || Cathodes !== e.cat) begin
                errors++;
                $display("FAIL %s lit d%0d: an=%b cat=%h required an=%b cat=%h",
                         name, d, Anodes, Cathodes, e.an, e.cat);
            end
            repeat (3) @(negedge Clock);
            checks++;
            if (Anodes !== 4'b1111 || Cathodes !== e.cat) begin
                errors++;
                $display("FAIL %s dead d%0d: an=%b cat=%h required an=1111 cat=%h",
                         name, d, Anodes, Cathodes, e.cat);
            end
        end
        checks++;
        if (FrameStart !== 1'b1) begin
            errors++;
            $display("FAIL %s frame_period: fs=%b required 1 after 16 cycles",
                     name, FrameStart);
        end
    endtask

    // Counts release edges up to the first FrameStart pulse.
    task automatic check_release(input string name);
        for (int k = 1; k <= 4; k++) begin
            @(negedge Clock);
            checks++;
            if (FrameStart !== (k == 4) || Anodes !== 4'b1111) begin
                errors++;
                $display("FAIL %s edge%0d: fs=%b an=%b required fs=%b an=1111",
                         name, k, FrameStart, Anodes, (k == 4));
            end
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        Enable = 1'b1;
        Digits = 16'h1234;
        BlankMask = 4'b0000;
        BlinkMask = 4'b0000;
        LeadZeroBlank = 1'b0;
        repeat (3) @(posedge Clock);
        @(negedge Clock);
        checks++;
        if (Cathodes !== 8'hFF || Anodes !== 4'b1111 || FrameStart !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: cat=%h an=%b fs=%b required FF 1111 0",
                     Cathodes, Anodes, FrameStart);
        end
        Reset = 1'b0;
        check_release("reset_release");
        push_frame(16'h1234, 4'b0, 4'b0, 1'b0, 1'b0);
        check_frame("scan_1234", 1'b0);
    endtask

    task automatic test_scan_repeat();
        push_frame(16'h1234, 4'b0, 4'b0, 1'b0, 1'b0);
        check_frame("scan_repeat", 1'b0);
    endtask

    task automatic test_lzb();
        Digits = 16'h0070;
        LeadZeroBlank = 1'b1;
        push_frame(16'h0070, 4'b0, 4'b0, 1'b1, 1'b0);
        check_frame("lzb_0070", 1'b1);
        Digits = 16'h0000;
        push_frame(16'h0000, 4'b0, 4'b0, 1'b1, 1'b0);
        check_frame("lzb_0000", 1'b1);
        LeadZeroBlank = 1'b0;
        push_frame(16'h0000, 4'b0, 4'b0, 1'b0, 1'b0);
        check_frame("nolzb_0000", 1'b1);
    endtask

    task automatic test_snapshot();
        Digits = 16'h9ABC;
        push_frame(16'h9ABC, 4'b0, 4'b0, 1'b0, 1'b0);
        fork
            check_frame("snap_9abc", 1'b1);
            begin
                bit ok2;
                wait_fs(1'b1, ok2);
                repeat (6) @(negedge Clock);
                Digits = 16'h1111;
            end
        join
        push_frame(16'h1111, 4'b0, 4'b0, 1'b0, 1'b0);
        check_frame("snap_1111", 1'b0);
    endtask

    task automatic test_enable();
        bit ok;
        Digits = 16'h1234;
        wait_fs(1'b1, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL enable_sync: no frame start within 40 cycles");
            return;
        end
        @(negedge Clock);
        checks++;
        if (Anodes !== 4'b1110 || Cathodes !== 8'h99) begin
            errors++;
            $display("FAIL enable_pre: an=%b cat=%h required 1110 99",
                     Anodes, Cathodes);
        end
        @(negedge Clock);
        Enable = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge Clock);
            checks++;
            if (Anodes !== 4'b1111 || Cathodes !== 8'hFF || FrameStart !== 1'b0) begin
                errors++;
                $display("FAIL enable_off c%0d: an=%b cat=%h fs=%b required 1111 FF 0",
                         k, Anodes, Cathodes, FrameStart);
            end
        end
        Enable = 1'b1;
        repeat (2) @(negedge Clock);
        checks++;
        if (Anodes !== 4'b1111) begin
            errors++;
            $display("FAIL enable_resume_dark: an=%b required 1111", Anodes);
        end
        @(negedge Clock);
        checks++;
        if (Anodes !== 4'b1101 || Cathodes !== 8'h0D) begin
            errors++;
            $display("FAIL enable_resume: an=%b cat=%h required 1101 0D",
                     Anodes, Cathodes);
        end
    endtask

    task automatic test_blink();
        Reset = 1'b1;
        Digits = 16'h1234;
        BlankMask = 4'b0010;
        BlinkMask = 4'b0001;
        LeadZeroBlank = 1'b0;
        repeat (2) @(negedge Clock);
        Reset = 1'b0;
        for (int f = 0; f < 4; f++) begin
            push_frame(16'h1234, 4'b0010, 4'b0001, 1'b0, (f >= 2));
            check_frame($sformatf("blink_f%0d", f), 1'b0);
        end
        BlankMask = 4'b0000;
        BlinkMask = 4'b0000;
    endtask

    task automatic test_reset_midscan();
        bit ok;
        wait_fs(1'b1, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL midreset_sync: no frame start within 40 cycles");
            return;
        end
        repeat (6) @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);
        checks++;
        if (Anodes !== 4'b1111 || Cathodes !== 8'hFF || FrameStart !== 1'b0) begin
            errors++;
            $display("FAIL midreset_state: an=%b cat=%h fs=%b required 1111 FF 0",
                     Anodes, Cathodes, FrameStart);
        end
        Reset = 1'b0;
        check_release("midreset_release");
        @(negedge Clock);
        checks++;
        if (Anodes !== 4'b1110 || Cathodes !== 8'h99) begin
            errors++;
            $display("FAIL midreset_first: an=%b cat=%h required 1110 99",
                     Anodes, Cathodes);
        end
    endtask

    initial begin
        test_reset();
        test_scan_repeat();
        test_lzb();
        test_snapshot();
        test_enable();
        test_blink();
        test_reset_midscan();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
